// File: rtl/sap_1_controller_sequencer.sv
// rtl/sap_1_controller_sequencer.sv - SAP-1 ring-counter sequencer and control-word decoder
// State advances on the falling clock edge so CON is settled at every rising edge.
module sap_1_controller_sequencer (
  input  logic        Clk,
  input  logic        CLRbar,
  input  logic [3:0]  opcode,
  output logic [11:0] CON,
  output logic [5:0]  T,
  output logic        HLTbar
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Control word bit map: Cp Ep LMbar CEbar LIbar EIbar LAbar EA Su EU LBbar LObar
  localparam logic [11:0] CW_IDLE  = 12'h3E3;
  localparam logic [11:0] CW_ADDR  = 12'h5E3;
  localparam logic [11:0] CW_INCR  = 12'hBE3;
  localparam logic [11:0] CW_MEM   = 12'h263;
  localparam logic [11:0] CW_IRADR = 12'h1A3;
  localparam logic [11:0] CW_LDA5  = 12'h2C3;
  localparam logic [11:0] CW_LDB5  = 12'h2E1;
  localparam logic [11:0] CW_ADD6  = 12'h3C7;
  localparam logic [11:0] CW_SUB6  = 12'h3CF;
  localparam logic [11:0] CW_OUT4  = 12'h3F2;

  ring_t state;

  always_ff @(negedge Clk or negedge CLRbar) begin
    if (!CLRbar) begin
      state  <= T1;
      HLTbar <= 1'b1;
    end else if (HLTbar) begin
      case (state)
        T1: state <= T2;
        T2: state <= T3;
        T3: begin
          state <= T4;
          // Halt is only sampled on the T3->T4 edge; the counter then freezes at T4.
          if (opcode == OP_HLT) HLTbar <= 1'b0;
        end
        T4: state <= T5;
        T5: state <= T6;
        T6: state <= T1;
        default: state <= T1;
      endcase
    end
  end

  assign T = state;

  always_comb begin
    CON = CW_IDLE;
    case (state)
      T1: CON = CW_ADDR;
      T2: CON = CW_INCR;
      T3: CON = CW_MEM;
      T4: begin
        if (HLTbar) begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: CON = CW_IRADR;
            OP_OUT:                 CON = CW_OUT4;
            default:                CON = CW_IDLE;
          endcase
        end
      end
      T5: begin
        case (opcode)
          OP_LDA:         CON = CW_LDA5;
          OP_ADD, OP_SUB: CON = CW_LDB5;
          default:        CON = CW_IDLE;
        endcase
      end
      T6: begin
        case (opcode)
          OP_ADD:  CON = CW_ADD6;
          OP_SUB:  CON = CW_SUB6;
          default: CON = CW_IDLE;
        endcase
      end
      default: CON = CW_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// tb/tb_sap_1_controller_sequencer.sv - scoreboard bench for the SAP-1 controller/sequencer
module tb_sap_1_controller_sequencer;

  logic        Clk;
  logic        CLRbar;
  logic [3:0]  opcode;
  logic [11:0] CON;
  logic [5:0]  T;
  logic        HLTbar;

  typedef struct packed {
    logic [5:0]  t;
    logic [11:0] con;
    logic        hlt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cmp = 0;
  int   mis = 0;

  sap_1_controller_sequencer dut (
    .Clk(Clk), .CLRbar(CLRbar), .opcode(opcode),
    .CON(CON), .T(T), .HLTbar(HLTbar)
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  function automatic exp_t mk(input logic [5:0] t, input logic [11:0] con, input logic hlt);
    exp_t r;
    r.t = t; r.con = con; r.hlt = hlt;
    return r;
  endfunction

  task automatic do_reset(input logic [3:0] op);
    @(posedge Clk); #2;
    CLRbar = 1'b0;
    opcode = op;
    @(posedge Clk); #2;
    CLRbar = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge Clk);
    cmp++;
    if ({T, CON, HLTbar} !== {6'b000001, 12'h5E3, 1'b1}) begin
      mis++;
      $display("FAIL reset_hold: got T=%b CON=%h HLTbar=%b want T=000001 CON=5e3 HLTbar=1", T, CON, HLTbar);
    end
    #2 CLRbar = 1'b1;
    sb.push_back(mk(6'b000010, 12'hBE3, 1'b1));
    sb.push_back(mk(6'b000100, 12'h263, 1'b1));
    sb.push_back(mk(6'b001000, 12'h1A3, 1'b1));
    sb.push_back(mk(6'b010000, 12'h2C3, 1'b1));
    sb.push_back(mk(6'b100000, 12'h3E3, 1'b1));
    sb.push_back(mk(6'b000001, 12'h5E3, 1'b1));
    sb.push_back(mk(6'b000010, 12'hBE3, 1'b1));
    repeat (7) begin
      @(posedge Clk);
      e = sb.pop_front();
      cmp++;
      if ({T, CON, HLTbar} !== e) begin
        mis++;
        $display("FAIL lda_run: got T=%b CON=%h HLTbar=%b want T=%b CON=%h HLTbar=%b", T, CON, HLTbar, e.t, e.con, e.hlt);
      end
      cmp++;
      if ($countones(T) != 1) begin mis++; $display("FAIL onehot_lda: got T=%b want one-hot", T); end
    end
  endtask

  task automatic test_add_sub;
    do_reset(4'b0001);
    sb.push_back(mk(6'b000010, 12'hBE3, 1'b1));
    sb.push_back(mk(6'b000100, 12'h263, 1'b1));
    sb.push_back(mk(6'b001000, 12'h1A3, 1'b1));
    sb.push_back(mk(6'b010000, 12'h2E1, 1'b1));
    sb.push_back(mk(6'b100000, 12'h3C7, 1'b1));
    sb.push_back(mk(6'b000001, 12'h5E3, 1'b1));
    sb.push_back(mk(6'b000010, 12'hBE3, 1'b1));
    sb.push_back(mk(6'b000100, 12'h263, 1'b1));
    sb.push_back(mk(6'b001000, 12'h1A3, 1'b1));
    sb.push_back(mk(6'b010000, 12'h2E1, 1'b1));
    sb.push_back(mk(6'b100000, 12'h3CF, 1'b1));
    sb.push_back(mk(6'b000001, 12'h5E3, 1'b1));
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk);
      e = sb.pop_front();
      cmp++;
      if ({T, CON, HLTbar} !== e) begin
        mis++;
        $display("FAIL add_sub step %0d: got T=%b CON=%h HLTbar=%b want T=%b CON=%h HLTbar=%b", i, T, CON, HLTbar, e.t, e.con, e.hlt);
      end
      cmp++;
      if ($countones(T) != 1) begin mis++; $display("FAIL onehot_add_sub: got T=%b want one-hot", T); end
      if (i == 5) opcode = 4'b0010;
    end
  endtask

  task automatic test_out_nop;
    do_reset(4'b1110);
    sb.push_back(mk(6'b000010, 12'hBE3, 1'b1));
    sb.push_back(mk(6'b000100, 12'h263, 1'b1));
    sb.push_back(mk(6'b001000, 12'h3F2, 1'b1));
    sb.push_back(mk(6'b010000, 12'h3E3, 1'b1));
    sb.push_back(mk(6'b100000, 12'h3E3, 1'b1));
    sb.push_back(mk(6'b000001, 12'h5E3, 1'b1));
    sb.push_back(mk(6'b000010, 12'hBE3, 1'b1));
    sb.push_back(mk(6'b000100, 12'h263, 1'b1));
    sb.push_back(mk(6'b001000, 12'h3E3, 1'b1));
    sb.push_back(mk(6'b010000, 12'h3E3, 1'b1));
    sb.push_back(mk(6'b100000, 12'h3E3, 1'b1));
    sb.push_back(mk(6'b000001, 12'h5E3, 1'b1));
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk);
      e = sb.pop_front();
      cmp++;
      if ({T, CON, HLTbar} !== e) begin
        mis++;
        $display("FAIL out_nop step %0d: got T=%b CON=%h HLTbar=%b want T=%b CON=%h HLTbar=%b", i, T, CON, HLTbar, e.t, e.con, e.hlt);
      end
      cmp++;
      if ($countones(T) != 1) begin mis++; $display("FAIL onehot_out_nop: got T=%b want one-hot", T); end
      // HLT presented during T1/T2 only must neither change CON nor halt.
      if (i == 5) opcode = 4'b1111;
      if (i == 7) opcode = 4'b0101;
    end
  endtask

  task automatic test_halt;
    do_reset(4'b1111);
    sb.push_back(mk(6'b000010, 12'hBE3, 1'b1));
    sb.push_back(mk(6'b000100, 12'h263, 1'b1));
    for (int k = 0; k < 13; k++) sb.push_back(mk(6'b001000, 12'h3E3, 1'b0));
    for (int i = 0; i < 15; i++) begin
      @(posedge Clk);
      e = sb.pop_front();
      cmp++;
      if ({T, CON, HLTbar} !== e) begin
        mis++;
        $display("FAIL halt step %0d: got T=%b CON=%h HLTbar=%b want T=%b CON=%h HLTbar=%b", i, T, CON, HLTbar, e.t, e.con, e.hlt);
      end
      cmp++;
      if ($countones(T) != 1) begin mis++; $display("FAIL onehot_halt: got T=%b want one-hot", T); end
      if (i >= 2) opcode = 4'($urandom_range(0, 15));
    end
    #2 CLRbar = 1'b0;
    opcode = 4'b0000;
    #1;
    cmp++;
    if ({T, CON, HLTbar} !== {6'b000001, 12'h5E3, 1'b1}) begin
      mis++;
      $display("FAIL halt_clear: got T=%b CON=%h HLTbar=%b want T=000001 CON=5e3 HLTbar=1", T, CON, HLTbar);
    end
    #1 CLRbar = 1'b1;
    @(posedge Clk);
    cmp++;
    if ({T, CON, HLTbar} !== {6'b000010, 12'hBE3, 1'b1}) begin
      mis++;
      $display("FAIL halt_restart: got T=%b CON=%h HLTbar=%b want T=000010 CON=be3 HLTbar=1", T, CON, HLTbar);
    end
  endtask

  task automatic test_async_reset;
    do_reset(4'b0001);
    sb.push_back(mk(6'b000010, 12'hBE3, 1'b1));
    sb.push_back(mk(6'b000100, 12'h263, 1'b1));
    sb.push_back(mk(6'b001000, 12'h1A3, 1'b1));
    sb.push_back(mk(6'b010000, 12'h2E1, 1'b1));
    repeat (4) begin
      @(posedge Clk);
      e = sb.pop_front();
      cmp++;
      if ({T, CON, HLTbar} !== e) begin
        mis++;
        $display("FAIL async_pre: got T=%b CON=%h HLTbar=%b want T=%b CON=%h HLTbar=%b", T, CON, HLTbar, e.t, e.con, e.hlt);
      end
      cmp++;
      if ($countones(T) != 1) begin mis++; $display("FAIL onehot_async: got T=%b want one-hot", T); end
    end
    #2 CLRbar = 1'b0;
    #1;
    cmp++;
    if ({T, CON, HLTbar} !== {6'b000001, 12'h5E3, 1'b1}) begin
      mis++;
      $display("FAIL async_mid_t5: got T=%b CON=%h HLTbar=%b want T=000001 CON=5e3 HLTbar=1", T, CON, HLTbar);
    end
    #1 CLRbar = 1'b1;
    @(posedge Clk);
    cmp++;
    if ({T, CON, HLTbar} !== {6'b000010, 12'hBE3, 1'b1}) begin
      mis++;
      $display("FAIL async_restart: got T=%b CON=%h HLTbar=%b want T=000010 CON=be3 HLTbar=1", T, CON, HLTbar);
    end
  endtask

  initial begin
    CLRbar = 1'b0;
    opcode = 4'b0000;
    test_reset();
    test_add_sub();
    test_out_nop();
    test_halt();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
